// File: rtl/ahb_intc.sv
// AHB3-Lite interrupt aggregator: pending/enable/edge/claim registers feeding msip/mtip/meip.
// Optional rising-edge line support is compiled in with `define INTC_EDGE_EN.
module ahb_intc #(
   parameter int NIRQ = 8
) (
   input  logic            s_clk_i,
   input  logic            s_reset_i,
   input  logic [31:0]     s_haddr_i,
   input  logic [31:0]     s_hwdata_i,
   input  logic [2:0]      s_hsize_i,
   input  logic [1:0]      s_htrans_i,
   input  logic            s_hwrite_i,
   input  logic            s_hsel_i,
   output logic [31:0]     s_hrdata_o,
   output logic            s_hready_o,
   output logic            s_hresp_o,
   input  logic            s_timer_irq_i,
   input  logic [NIRQ-1:0] s_irq_i,
   output logic            s_msip_o,
   output logic            s_mtip_o,
   output logic            s_meip_o
);

   localparam logic [2:0] A_CTRL  = 3'd0;
   localparam logic [2:0] A_PEND  = 3'd1;
   localparam logic [2:0] A_EN    = 3'd2;
   localparam logic [2:0] A_EDGE  = 3'd3;
   localparam logic [2:0] A_CLAIM = 3'd4;

   logic            dphase_reg, write_reg, err1_reg, err2_reg;
   logic [2:0]      addr_reg;
   logic            accept, bad, wr, rd;
   logic [NIRQ-1:0] wdata;
   logic            msip_reg, mtie_reg;
   logic [NIRQ-1:0] irq_q, pending_reg, pending_next, enable_reg, edge_reg, pend_en;
   logic [NIRQ-1:0] edge_set, edge_clr, edge_chg;
   logic [5:0]      claim_id;
   logic [31:0]     rdata;
   logic            unused_bits;

   assign unused_bits = &{1'b0, s_haddr_i[31:5], s_haddr_i[1:0], s_htrans_i[0], s_hwdata_i[31:NIRQ]};

   // Error responses stall one cycle (hready low) and finish with hready high, hresp still high.
   assign s_hready_o = ~err1_reg;
   assign s_hresp_o  = err1_reg | err2_reg;
   assign accept     = s_hsel_i & s_hready_o & s_htrans_i[1];
   assign bad        = (s_haddr_i[4:2] > A_CLAIM) || (s_hsize_i != 3'b010);
   assign wr         = dphase_reg & write_reg;
   assign rd         = dphase_reg & ~write_reg;
   assign wdata      = s_hwdata_i[NIRQ-1:0];

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         dphase_reg <= 1'b0;
         write_reg  <= 1'b0;
         err1_reg   <= 1'b0;
         err2_reg   <= 1'b0;
         addr_reg   <= '0;
      end else begin
         dphase_reg <= accept & ~bad;
         err1_reg   <= accept & bad;
         err2_reg   <= err1_reg;
         if (accept) begin
            addr_reg  <= s_haddr_i[4:2];
            write_reg <= s_hwrite_i;
         end
      end
   end

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         msip_reg   <= 1'b0;
         mtie_reg   <= 1'b0;
         enable_reg <= '0;
         irq_q      <= '0;
         pending_reg <= '0;
      end else begin
         irq_q       <= s_irq_i;
         pending_reg <= pending_next;
         if (wr && addr_reg == A_CTRL) begin
            msip_reg <= s_hwdata_i[0];
            mtie_reg <= s_hwdata_i[1];
         end
         if (wr && addr_reg == A_EN)
            enable_reg <= wdata;
      end
   end

   assign pend_en = pending_reg & enable_reg;

`ifdef INTC_EDGE_EN
   logic [NIRQ-1:0] irq_prev;
   logic [NIRQ-1:0] claim_oh;

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         irq_prev <= '0;
         edge_reg <= '0;
      end else begin
         irq_prev <= irq_q;
         if (wr && addr_reg == A_EDGE)
            edge_reg <= wdata;
      end
   end

   // Isolates the lowest enabled pending line, i.e. the one a CLAIM read returns.
   assign claim_oh = pend_en & (~pend_en + NIRQ'(1));
   assign edge_set = irq_q & ~irq_prev;
   assign edge_chg = (wr && addr_reg == A_EDGE) ? (wdata ^ edge_reg) : '0;
   assign edge_clr = ((wr && addr_reg == A_PEND) ? wdata : '0)
                   | ((rd && addr_reg == A_CLAIM) ? claim_oh : '0);
`else
   assign edge_reg = '0;
   assign edge_set = '0;
   assign edge_chg = '0;
   assign edge_clr = '0;
`endif

   // A mode change always drops the line; otherwise a new edge beats a same-cycle clear.
   for (genvar gi = 0; gi < NIRQ; gi++) begin : g_pend
      assign pending_next[gi] = edge_chg[gi] ? 1'b0 :
                                edge_reg[gi] ? (edge_set[gi] | (pending_reg[gi] & ~edge_clr[gi])) :
                                               irq_q[gi];
   end

   always_comb begin
      claim_id = '0;
      for (int i = NIRQ - 1; i >= 0; i--)
         if (pend_en[i]) claim_id = 6'(i + 1);
   end

   always_comb begin
      rdata = '0;
      if (rd) begin
         case (addr_reg)
            A_CTRL:  rdata[1:0]      = {mtie_reg, msip_reg};
            A_PEND:  rdata[NIRQ-1:0] = pending_reg;
            A_EN:    rdata[NIRQ-1:0] = enable_reg;
            A_EDGE:  rdata[NIRQ-1:0] = edge_reg;
            A_CLAIM: rdata           = 32'(claim_id);
            default: rdata           = '0;
         endcase
      end
   end
   assign s_hrdata_o = rdata;

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         s_meip_o <= 1'b0;
         s_mtip_o <= 1'b0;
         s_msip_o <= 1'b0;
      end else begin
         s_meip_o <= |pend_en;
         s_mtip_o <= s_timer_irq_i & mtie_reg;
         s_msip_o <= msip_reg;
      end
   end

endmodule

// File: tb/tb_ahb_intc.sv
// Directed + randomized bench for ahb_intc; compile with +define+INTC_EDGE_EN to add edge-line steps.
module tb_ahb_intc;
   localparam int NIRQ = 8;

   logic            clk = 1'b0;
   logic            srst = 1'b1;
   logic [31:0]     haddr = '0, hwdata = '0, hrdata;
   logic [2:0]      hsize = 3'b010;
   logic [1:0]      htrans = 2'b00;
   logic            hwrite = 1'b0, hsel = 1'b0;
   logic            hready, hresp;
   logic            timer_irq = 1'b0;
   logic [NIRQ-1:0] irq = '0;
   logic            msip, mtip, meip;

   int checks = 0;
   int errors = 0;
   bit chk_meip = 0;
   bit rand_irq = 0;
   logic [NIRQ-1:0] en_model = '0;
   logic [NIRQ-1:0] hist[$];   // hist[0] = line values captured at the most recent edge
   logic [31:0]     rd_val;

   ahb_intc #(.NIRQ(NIRQ)) dut (
      .s_clk_i(clk), .s_reset_i(srst), .s_haddr_i(haddr), .s_hwdata_i(hwdata),
      .s_hsize_i(hsize), .s_htrans_i(htrans), .s_hwrite_i(hwrite), .s_hsel_i(hsel),
      .s_hrdata_o(hrdata), .s_hready_o(hready), .s_hresp_o(hresp),
      .s_timer_irq_i(timer_irq), .s_irq_i(irq),
      .s_msip_o(msip), .s_mtip_o(mtip), .s_meip_o(meip)
   );

   always #5 clk = ~clk;

   // Reference: what the block captured from the lines at each edge (zero while in reset).
   always @(posedge clk) begin
      hist.push_front(srst ? '0 : irq);
      if (hist.size() > 8) void'(hist.pop_back());
   end

   function automatic logic [NIRQ-1:0] h(input int n);
      return (n < hist.size()) ? hist[n] : '0;
   endfunction

   function automatic logic [31:0] claim_of(input logic [NIRQ-1:0] p);
      for (int i = 0; i < NIRQ; i++)
         if (p[i]) return 32'(i + 1);
      return 32'd0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Level line: pending follows the line one edge late, meip one edge after that.
   task automatic step();
      @(negedge clk);
      if (chk_meip) check("meip_model", 32'(meip), 32'(|(h(2) & en_model)));
      if (rand_irq) irq = NIRQ'($urandom);
   endtask

   task automatic idle_bus();
      htrans = 2'b00; hsel = 1'b0; hwrite = 1'b0; hsize = 3'b010;
   endtask

   task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
      haddr = a; hwrite = w; hsize = sz; htrans = 2'b10; hsel = 1'b1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      step(); addr_phase(a, 1'b1, 3'b010);
      step(); idle_bus(); hwdata = d;
      check("wr_hready", 32'(hready), 32'd1);
      check("wr_hresp", 32'(hresp), 32'd0);
      $display("write addr=%h data=%h", a, d);
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      step(); addr_phase(a, 1'b0, 3'b010);
      step(); idle_bus();
      check("rd_hready", 32'(hready), 32'd1);
      check("rd_hresp", 32'(hresp), 32'd0);
      d = hrdata;
      $display("read  addr=%h data=%h", a, d);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_meip", 32'(meip), 32'd0);
      srst = 1'b0;
      @(negedge clk);
      check("rst_outs", {28'd0, msip, mtip, meip, hresp}, 32'd0);
      check("rst_hready", 32'(hready), 32'd1);
      check("rst_hrdata", hrdata, 32'd0);

      // CTRL: software bit and timer enable
      bus_write(32'h00, 32'h3);
      step();
      check("msip_early", 32'(msip), 32'd0);
      check("mtip_idle", 32'(mtip), 32'd0);
      timer_irq = 1'b1;
      step();
      check("msip_set", 32'(msip), 32'd1);
      check("mtip_set", 32'(mtip), 32'd1);
      bus_read(32'h00, rd_val);
      check("ctrl_rd", rd_val, 32'h3);
      timer_irq = 1'b0;
      bus_write(32'h00, 32'h0);
      step(); step();
      check("ctrl_clr", {30'd0, msip, mtip}, 32'd0);

      // Level line 2 held for four cycles
      bus_write(32'h08, 32'h05);
      en_model = 8'h05;
      step(); step(); step();
      chk_meip = 1;
      irq = 8'h04;
      step();
      bus_read(32'h10, rd_val);
      check("claim_lvl", rd_val, 32'd3);
      step();
      irq = 8'h00;
      repeat (4) step();
      check("meip_fall", 32'(meip), 32'd0);
      chk_meip = 0;

      // Back-to-back write then read of ENABLE
      step(); addr_phase(32'h08, 1'b1, 3'b010);
      step(); hwdata = 32'hFF; addr_phase(32'h08, 1'b0, 3'b010);
      step(); idle_bus();
      check("b2b_hready", 32'(hready), 32'd1);
      check("b2b_rdata", hrdata, 32'h0000_00FF);
      en_model = 8'hFF;
      $display("b2b   enable write/read data=%h", hrdata);

      // Error responses: unmapped offset, then byte write issued in the second error cycle
      step(); addr_phase(32'h14, 1'b0, 3'b010);
      step(); idle_bus();
      check("err1_rdy", {31'd0, hready}, 32'd0);
      check("err1_resp", 32'(hresp), 32'd1);
      step();
      check("err2_rdy", 32'(hready), 32'd1);
      check("err2_resp", 32'(hresp), 32'd1);
      addr_phase(32'h08, 1'b1, 3'b000);
      step(); idle_bus(); hwdata = 32'h0;
      check("berr1_rdy", 32'(hready), 32'd0);
      check("berr1_resp", 32'(hresp), 32'd1);
      step();
      check("berr2_rdy", 32'(hready), 32'd1);
      check("berr2_resp", 32'(hresp), 32'd1);
      $display("error sequence done");
      bus_read(32'h08, rd_val);
      check("en_kept", rd_val, 32'hFF);

`ifdef INTC_EDGE_EN
      bus_write(32'h08, 32'h01);
      en_model = 8'h01;
      bus_write(32'h0C, 32'h01);
      step(); step();
      irq = 8'h01; step(); irq = 8'h00;
      repeat (3) step();
      bus_read(32'h04, rd_val);
      check("edge_pend", rd_val, 32'h1);
      check("edge_meip", 32'(meip), 32'd1);
      bus_read(32'h10, rd_val);
      check("edge_claim1", rd_val, 32'd1);
      bus_read(32'h10, rd_val);
      check("edge_claim0", rd_val, 32'd0);
      step(); step();
      check("edge_meip0", 32'(meip), 32'd0);
      // Rearm, then W1C lands in the same cycle as a fresh rising edge
      irq = 8'h01; step(); irq = 8'h00;
      repeat (3) step();
      step(); addr_phase(32'h04, 1'b1, 3'b010); irq = 8'h01;
      step(); idle_bus(); hwdata = 32'h1; irq = 8'h00;
      step();
      bus_read(32'h04, rd_val);
      check("w1c_race", rd_val, 32'h1);
      bus_write(32'h04, 32'h1);
      bus_read(32'h04, rd_val);
      check("w1c_clr", rd_val, 32'h0);
      bus_write(32'h0C, 32'h00);
      step();
`endif

      // Randomized lines against the reference, several enable masks
      rand_irq = 1;
      for (int r = 0; r < 6; r++) begin
         logic [31:0] en_w;
         en_w = $urandom;
         bus_write(32'h08, en_w);
         en_model = en_w[NIRQ-1:0];
         repeat (3) step();
         chk_meip = 1;
         for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 2))
               0: step();
               1: begin
                  bus_read(32'h04, rd_val);
                  check("rnd_pend", rd_val, 32'(h(1)));
               end
               default: begin
                  bus_read(32'h10, rd_val);
                  check("rnd_claim", rd_val, claim_of(h(1) & en_model));
               end
            endcase
         end
         chk_meip = 0;
      end
      rand_irq = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
